// File: rtl/i2c_resp_pkg.sv
// Shared widths and FSM state encoding for the I2C responder.
package i2c_resp_pkg;

    localparam int I2C_ADDR_WIDTH = 7;
    localparam int I2C_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } state_e;

endpackage

// File: rtl/i2c_resp_sync.sv
// Synchronizes SCL/SDA into clk_i and flags SCL edges plus START/STOP conditions.
module i2c_resp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Presetting to 1 matches an idle bus, so leaving reset creates no edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign sda_s_o    = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_responder.sv
// I2C target: answers one 7-bit address, streams write bytes out and read bytes in.
module i2c_responder
    import i2c_resp_pkg::*;
#(
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR  = 7'h22,
    parameter int                        SYNC_STAGES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
    output logic                      wr_valid_o,
    output logic                      rd_req_o,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      busy_o
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_resp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_s_o    (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    state_e                    state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [I2C_DATA_WIDTH-1:0] rx_q, rx_d, rx_next;
    logic [I2C_DATA_WIDTH-1:0] tx_q, tx_d;
    logic [I2C_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                      sda_q, sda_d;
    logic                      rw_q, rw_d;
    logic                      wr_valid_q, wr_valid_d;
    logic                      rd_req_q, rd_req_d;
    logic                      rd_load_q;
    logic                      busy_q, busy_d;
    logic                      start_q, stop_q;

    assign rx_next = {rx_q[I2C_DATA_WIDTH-2:0], sda_s};

    // In the ACK states cnt_q==0 waits for the fall that starts our drive, 1 for the fall that ends it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        sda_d      = sda_q;
        rw_d       = rw_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        busy_d     = busy_q;

        if (rd_load_q) begin
            tx_d = rd_data_i;
        end

        if (stop_det) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = 3'd0;
            rx_d    = '0;
            sda_d   = 1'b1;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            cnt_d   = 3'd0;
                            rw_d    = sda_s;
                            state_d = (rx_next[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd0) begin
                            sda_d = 1'b0;
                            cnt_d = 3'd1;
                        end else begin
                            cnt_d = 3'd0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_d = ST_RD_DATA;
                                sda_d   = tx_q[7];
                                tx_d    = {tx_q[6:0], 1'b0};
                            end else begin
                                state_d = ST_WR_DATA;
                                sda_d   = 1'b1;
                            end
                        end
                    end else if (scl_rise && state_q == ST_ADDR_ACK && rw_q && cnt_q == 3'd1) begin
                        rd_req_d = 1'b1;
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            cnt_d      = 3'd0;
                            wr_data_d  = rx_next;
                            wr_valid_d = 1'b1;
                            state_d    = ST_WR_ACK;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            cnt_d   = 3'd0;
                            sda_d   = 1'b1;
                            state_d = ST_RD_ACK;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            sda_d = tx_q[7];
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (cnt_q == 3'd0 && scl_rise) begin
                        if (!sda_s) begin
                            rd_req_d = 1'b1;
                            cnt_d    = 3'd1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (cnt_q == 3'd1 && scl_fall) begin
                        cnt_d   = 3'd0;
                        state_d = ST_RD_DATA;
                        sda_d   = tx_q[7];
                        tx_d    = {tx_q[6:0], 1'b0};
                    end
                end
                default: begin
                    sda_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            rx_q       <= '0;
            tx_q       <= '0;
            wr_data_q  <= '0;
            sda_q      <= 1'b1;
            rw_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_load_q  <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            wr_data_q  <= wr_data_d;
            sda_q      <= sda_d;
            rw_q       <= rw_d;
            wr_valid_q <= wr_valid_d;
            rd_req_q   <= rd_req_d;
            rd_load_q  <= rd_req_q;
            busy_q     <= busy_d;
            start_q    <= start_det;
            stop_q     <= stop_det;
        end
    end

    assign sda_o      = sda_q;
    assign wr_data_o  = wr_data_q;
    assign wr_valid_o = wr_valid_q;
    assign rd_req_o   = rd_req_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_responder.sv
// Directed bench for i2c_responder: bit-banged master on a wired-AND SDA line.
module tb_i2c_responder;
    import i2c_resp_pkg::*;

    localparam int Q = 5;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_o_w;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       start_p;
    logic       stop_p;
    logic       busy;

    assign sda_bus = sda_m & sda_o_w;

    i2c_responder #(.SLAVE_ADDR(7'h22), .SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (scl_m),
        .sda_i      (sda_bus),
        .sda_o      (sda_o_w),
        .wr_data_o  (wr_data),
        .wr_valid_o (wr_valid),
        .rd_req_o   (rd_req),
        .rd_data_i  (rd_data),
        .start_o    (start_p),
        .stop_o     (stop_p),
        .busy_o     (busy)
    );

    // Monitor: cumulative event counters and captured write bytes
    int         n_rd = 0, n_start = 0, n_stop = 0, n_low = 0;
    logic [7:0] wr_got_q[$];

    always @(negedge clk) begin
        if (rd_req)   n_rd++;
        if (start_p)  n_start++;
        if (stop_p)   n_stop++;
        if (!sda_o_w) n_low++;
        if (wr_valid) wr_got_q.push_back(wr_data);
    end

    // Scoreboard
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         s_rd, s_start, s_stop, s_low;
    logic [7:0] exp_last;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic snap();
        s_rd    = n_rd;
        s_start = n_start;
        s_stop  = n_stop;
        s_low   = n_low;
    endtask

    task automatic sb_drain(input string name);
        check({name, "_wr_count"}, wr_got_q.size(), exp_q.size());
        while (wr_got_q.size() > 0 && exp_q.size() > 0)
            check({name, "_wr_data"}, wr_got_q.pop_front(), exp_q.pop_front());
        wr_got_q.delete();
        exp_q.delete();
    endtask

    // Bus driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(3 * Q);
    endtask

    task automatic send_bit(input logic b, output logic rb);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q);
        rb = sda_bus; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic rb;
        for (int i = 7; i >= 0; i--) begin
            send_bit(tx[i], rb);
            rx[i] = rb;
        end
        sda_m = 1'b1;
    endtask

    task automatic run_write(input logic [7:0] a, input logic [7:0] d,
                             output logic aack, output logic dack);
        logic [7:0] dummy;
        bus_start();
        xfer_byte(a, dummy);
        send_bit(1'b1, aack);
        xfer_byte(d, dummy);
        send_bit(1'b1, dack);
        bus_stop();
    endtask

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] data_byte;
        logic       exp_aack;
        logic       exp_dack;
        int         exp_low;
    } wr_vec_t;

    wr_vec_t vecs[6];

    initial begin
        logic       aack, dack, rb;
        logic [7:0] rx, dummy;

        vecs[0] = '{8'h44, 8'h78, 1'b0, 1'b0, 8 * Q};
        vecs[1] = '{8'h50, 8'h11, 1'b1, 1'b1, 0};
        vecs[2] = '{8'h44, 8'h00, 1'b0, 1'b0, 8 * Q};
        vecs[3] = '{8'h42, 8'h5A, 1'b1, 1'b1, 0};
        vecs[4] = '{8'h44, 8'hFF, 1'b0, 1'b0, 8 * Q};
        vecs[5] = '{8'hC4, 8'h33, 1'b1, 1'b1, 0};

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_data = 8'h00;
        exp_last = 8'h00;
        tick(5);
        check("reset_during", {sda_o_w, busy, wr_valid, rd_req, start_p, stop_p, wr_data},
              {1'b1, 5'b0, 8'h00});
        rst = 1'b0;
        tick(10);
        check("reset_after", {sda_o_w, busy, wr_valid, rd_req, start_p, stop_p, wr_data},
              {1'b1, 5'b0, 8'h00});

        // Table-driven write transactions
        for (int v = 0; v < 6; v++) begin
            snap();
            run_write(vecs[v].addr_byte, vecs[v].data_byte, aack, dack);
            if (!vecs[v].exp_aack) begin
                exp_q.push_back(vecs[v].data_byte);
                exp_last = vecs[v].data_byte;
            end
            check($sformatf("v%0d_addr_ack", v), aack, vecs[v].exp_aack);
            check($sformatf("v%0d_data_ack", v), dack, vecs[v].exp_dack);
            check($sformatf("v%0d_starts", v), n_start - s_start, 1);
            check($sformatf("v%0d_stops", v), n_stop - s_stop, 1);
            check($sformatf("v%0d_busy", v), busy, 1'b0);
            check($sformatf("v%0d_low_cycles", v), n_low - s_low, vecs[v].exp_low);
            check($sformatf("v%0d_wr_hold", v), wr_data, exp_last);
            sb_drain($sformatf("v%0d", v));
        end

        // Read: two bytes, master ACK then NACK
        snap();
        rd_data = 8'hA5;
        bus_start();
        check("rd_busy_mid", busy, 1'b1);
        xfer_byte(8'h45, dummy);
        send_bit(1'b1, aack);
        check("rd_addr_ack", aack, 1'b0);
        xfer_byte(8'hFF, rx);
        check("rd_byte0", rx, 8'hA5);
        rd_data = 8'h3C;
        send_bit(1'b0, rb);
        xfer_byte(8'hFF, rx);
        check("rd_byte1", rx, 8'h3C);
        send_bit(1'b1, rb);
        check("rd_nack_line", rb, 1'b1);
        bus_stop();
        check("rd_req_count", n_rd - s_rd, 2);
        check("rd_busy_end", busy, 1'b0);
        sb_drain("rd");

        // Repeated START after a partial write byte
        snap();
        rd_data = 8'h96;
        bus_start();
        xfer_byte(8'h44, dummy);
        send_bit(1'b1, aack);
        check("rs_first_ack", aack, 1'b0);
        send_bit(1'b1, rb); send_bit(1'b0, rb); send_bit(1'b1, rb); send_bit(1'b0, rb);
        bus_start();
        xfer_byte(8'h45, dummy);
        send_bit(1'b1, aack);
        check("rs_second_ack", aack, 1'b0);
        xfer_byte(8'hFF, rx);
        check("rs_rd_byte", rx, 8'h96);
        send_bit(1'b1, rb);
        bus_stop();
        check("rs_starts", n_start - s_start, 2);
        check("rs_rd_req", n_rd - s_rd, 1);
        check("rs_wr_hold", wr_data, exp_last);
        sb_drain("rs");

        // STOP after five data bits of a write
        snap();
        bus_start();
        xfer_byte(8'h44, dummy);
        send_bit(1'b1, aack);
        check("p5_addr_ack", aack, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0], rb);
        bus_stop();
        check("p5_busy", busy, 1'b0);
        check("p5_state", dut.state_q, ST_IDLE);
        check("p5_stops", n_stop - s_stop, 1);
        sb_drain("p5");

        // Reset while driving a 0 data bit, then a normal write
        rd_data = 8'h00;
        bus_start();
        xfer_byte(8'h45, dummy);
        send_bit(1'b1, aack);
        check("rst_rd_ack", aack, 1'b0);
        check("rst_driving_low", sda_o_w, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_sda_release", sda_o_w, 1'b1);
        check("rst_busy", busy, 1'b0);
        exp_last = 8'h00;
        check("rst_wr_data", wr_data, exp_last);
        tick(Q);
        bus_stop();
        tick(10);
        snap();
        run_write(8'h44, 8'h78, aack, dack);
        exp_q.push_back(8'h78);
        check("post_addr_ack", aack, 1'b0);
        check("post_data_ack", dack, 1'b0);
        check("post_starts", n_start - s_start, 1);
        check("post_stops", n_stop - s_stop, 1);
        sb_drain("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
